// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types for the hazard scoreboard: in-flight entry and forward-select codes.
// Zero latency (types/functions only); no flow control.
package cpu_pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic       valid;
    logic       wreg;
    logic       m2reg;
    logic [4:0] dest;
  } entry_t;

  // $0 is hardwired, so nothing ever produces it.
  function automatic logic produces(input logic valid, input logic wreg,
                                    input logic [4:0] dest, input logic [4:0] r);
    return valid && wreg && (dest == r) && (r != 5'd0);
  endfunction

  // Youngest producer wins.
  function automatic logic [1:0] fwd_sel(input logic h_ex, input logic h_mem, input logic h_wb);
    if (h_ex)       return FWD_EX;
    else if (h_mem) return FWD_MEM;
    else if (h_wb)  return FWD_WB;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and hazard-decision bundle between decode and the scoreboard.
// Combinational; no backpressure beyond the stall output itself.
interface hazard_scoreboard_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_wreg;
  logic [4:0]  id_dest;
  logic        id_m2reg;
  logic        id_flush;
  logic        stall;
  logic [1:0]  fwda;
  logic [1:0]  fwdb;
  logic [15:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_dest, id_m2reg, id_flush,
    input  stall, fwda, fwdb, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_dest, id_m2reg, id_flush,
    output stall, fwda, fwdb, stall_cnt
  );
endinterface

// File: rtl/hz_match.sv
// Per-source hit detection of one ID operand against the EX/MEM/WB entries.
// Combinational, zero latency; no flow control.
module hz_match
  import cpu_pipe_pkg::*;
(
  input  logic       id_valid,
  input  logic       use_src,
  input  logic [4:0] src,
  input  entry_t     ex,
  input  entry_t     mem,
  input  entry_t     wb,
  output logic       hit_ex,
  output logic       hit_mem,
  output logic       hit_wb
);

  logic consumed;
  logic unused_m2reg;

  assign consumed = id_valid && use_src && (src != 5'd0);

  assign hit_ex  = consumed && produces(ex.valid,  ex.wreg,  ex.dest,  src);
  assign hit_mem = consumed && produces(mem.valid, mem.wreg, mem.dest, src);
  assign hit_wb  = consumed && produces(wb.valid,  wb.wreg,  wb.dest,  src);

  // Load flag is only relevant to the stall decision made by the parent.
  assign unused_m2reg = ex.m2reg ^ mem.m2reg ^ wb.m2reg;

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard (EX/MEM/WB); stall/forward selects are same-cycle combinational.
// HZ_FORWARD_EN: defined = forwarding + load-use stall only; undefined = stall until the producer retires.
module hazard_scoreboard
  import cpu_pipe_pkg::*;
(
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave hz
);

  entry_t      ex_q, ex_d;
  entry_t      mem_q, mem_d;
  entry_t      wb_q, wb_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic rs_ex, rs_mem, rs_wb;
  logic rt_ex, rt_mem, rt_wb;
  logic stall_raw, stall;
  logic [1:0] fwda, fwdb;

  hz_match u_match_rs (
    .id_valid (hz.id_valid),
    .use_src  (hz.id_use_rs),
    .src      (hz.id_rs),
    .ex       (ex_q),
    .mem      (mem_q),
    .wb       (wb_q),
    .hit_ex   (rs_ex),
    .hit_mem  (rs_mem),
    .hit_wb   (rs_wb)
  );

  hz_match u_match_rt (
    .id_valid (hz.id_valid),
    .use_src  (hz.id_use_rt),
    .src      (hz.id_rt),
    .ex       (ex_q),
    .mem      (mem_q),
    .wb       (wb_q),
    .hit_ex   (rt_ex),
    .hit_mem  (rt_mem),
    .hit_wb   (rt_wb)
  );

  always_comb begin
    stall_raw = 1'b0;
    fwda      = FWD_RF;
    fwdb      = FWD_RF;
`ifdef HZ_FORWARD_EN
    stall_raw = ex_q.m2reg && (rs_ex || rt_ex);
    fwda      = fwd_sel(rs_ex, rs_mem, rs_wb);
    fwdb      = fwd_sel(rt_ex, rt_mem, rt_wb);
`else
    stall_raw = rs_ex || rs_mem || rs_wb || rt_ex || rt_mem || rt_wb;
`endif
    // A flushed instruction never issues, so its hazard is moot.
    stall = stall_raw && !hz.id_flush;

    ex_d = '0;
    if (hz.id_valid && !stall && !hz.id_flush) begin
      ex_d.valid = 1'b1;
      ex_d.wreg  = hz.id_wreg;
      ex_d.m2reg = hz.id_m2reg;
      ex_d.dest  = hz.id_dest;
    end
    mem_d = ex_q;
    wb_d  = mem_q;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.stall     = stall;
  assign hz.fwda      = fwda;
  assign hz.fwdb      = fwdb;
  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations follow the HZ_FORWARD_EN build setting.
module tb_hazard_scoreboard;
  import cpu_pipe_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   failures;
  int   exp_cnt;

  hazard_scoreboard_if hz_if ();

  hazard_scoreboard u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic wr,
                       input logic [4:0] dst, input logic ld, input logic fl);
    hz_if.id_valid  = v;
    hz_if.id_rs     = rs;
    hz_if.id_rt     = rt;
    hz_if.id_use_rs = urs;
    hz_if.id_use_rt = urt;
    hz_if.id_wreg   = wr;
    hz_if.id_dest   = dst;
    hz_if.id_m2reg  = ld;
    hz_if.id_flush  = fl;
    #1;
  endtask

  task automatic idle();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    repeat (3) begin
      idle();
      step();
    end
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    exp_cnt  = 0;
    rst      = 1'b1;
    idle();
    @(negedge clk);
    check("rst_stall", hz_if.stall, 0);
    check("rst_fwda", hz_if.fwda, FWD_RF);
    check("rst_fwdb", hz_if.fwdb, FWD_RF);
    check("rst_cnt", hz_if.stall_cnt, 0);
    rst = 1'b0;
    step();

    // Load-use: lw $5 in EX, ID reads rt=$5
    issue(1, 0, 0, 0, 0, 1, 5, 1, 0);
    check("lu_pre_stall", hz_if.stall, 0);
    step();
    issue(1, 0, 5, 0, 1, 1, 6, 0, 0);
    check("lu_stall", hz_if.stall, 1);
    step();
`ifdef HZ_FORWARD_EN
    check("lu_release", hz_if.stall, 0);
    check("lu_fwdb_mem", hz_if.fwdb, FWD_MEM);
    exp_cnt = 1;
`else
    check("lu_stall2", hz_if.stall, 1);
    step();
    check("lu_stall3", hz_if.stall, 1);
    step();
    check("lu_release", hz_if.stall, 0);
    check("lu_fwdb_rf", hz_if.fwdb, FWD_RF);
    exp_cnt = 3;
`endif
    check("lu_cnt", hz_if.stall_cnt, exp_cnt);
    step();
    drain();

    // Producer add $3 in EX, ID reads rs=$3
    issue(1, 0, 0, 0, 0, 1, 3, 0, 0);
    step();
    issue(1, 3, 0, 1, 0, 0, 0, 0, 0);
`ifdef HZ_FORWARD_EN
    check("ex_fwda", hz_if.fwda, FWD_EX);
    check("ex_stall", hz_if.stall, 0);
`else
    check("ex_stall1", hz_if.stall, 1);
    check("ex_fwda", hz_if.fwda, FWD_RF);
    step();
    check("ex_stall2", hz_if.stall, 1);
    step();
    check("ex_stall3", hz_if.stall, 1);
    step();
    check("ex_release", hz_if.stall, 0);
    exp_cnt += 3;
    check("ex_cnt", hz_if.stall_cnt, exp_cnt);
`endif
    step();
    drain();

    // Two writers of $4, reader follows
    issue(1, 0, 0, 0, 0, 1, 4, 0, 0);
    step();
    issue(1, 0, 0, 0, 0, 1, 4, 0, 0);
    step();
    issue(1, 4, 4, 1, 1, 0, 0, 0, 0);
`ifdef HZ_FORWARD_EN
    check("pri_ex_over_mem_a", hz_if.fwda, FWD_EX);
    check("pri_ex_over_mem_b", hz_if.fwdb, FWD_EX);
    step();
    check("pri_mem_over_wb", hz_if.fwda, FWD_MEM);
    step();
    check("pri_wb_only", hz_if.fwda, FWD_WB);
`else
    check("pri_stall1", hz_if.stall, 1);
    step();
    check("pri_stall2", hz_if.stall, 1);
    check("pri_fwda", hz_if.fwda, FWD_RF);
    step();
    check("pri_stall3", hz_if.stall, 1);
    step();
    check("pri_release", hz_if.stall, 0);
    exp_cnt += 3;
`endif
    step();
    drain();
    check("pri_cnt", hz_if.stall_cnt, exp_cnt);

    // $0 is never a hazard; wreg=0 is not a producer; self-use has no hazard
    issue(1, 0, 0, 0, 0, 1, 0, 0, 0);
    step();
    issue(1, 0, 0, 1, 1, 0, 0, 0, 0);
    check("r0_fwda", hz_if.fwda, FWD_RF);
    check("r0_fwdb", hz_if.fwdb, FWD_RF);
    check("r0_stall", hz_if.stall, 0);
    step();
    issue(1, 0, 0, 0, 0, 0, 6, 0, 0);
    step();
    issue(1, 6, 0, 1, 0, 0, 0, 0, 0);
    check("nowreg_stall", hz_if.stall, 0);
    check("nowreg_fwda", hz_if.fwda, FWD_RF);
    step();
    drain();
    issue(1, 8, 0, 1, 0, 1, 8, 0, 0);
    check("self_stall", hz_if.stall, 0);
    check("self_fwda", hz_if.fwda, FWD_RF);
    step();
    drain();

    // Flush overrides a load-use stall and sends a bubble into EX
    issue(1, 0, 0, 0, 0, 1, 5, 1, 0);
    step();
    issue(1, 0, 5, 0, 1, 1, 9, 0, 1);
    check("flush_stall", hz_if.stall, 0);
    step();
    issue(1, 9, 0, 1, 0, 0, 0, 0, 0);
    check("flush_bubble_stall", hz_if.stall, 0);
    check("flush_bubble_fwda", hz_if.fwda, FWD_RF);
    check("flush_cnt", hz_if.stall_cnt, exp_cnt);
    step();
    drain();

    // Reset asserted in the middle of a stall
    issue(1, 0, 0, 0, 0, 1, 10, 1, 0);
    step();
    issue(1, 10, 0, 1, 0, 0, 0, 0, 0);
    check("rstmid_stall_before", hz_if.stall, 1);
    rst = 1'b1;
    #1;
    check("rstmid_stall", hz_if.stall, 0);
    check("rstmid_fwda", hz_if.fwda, FWD_RF);
    check("rstmid_cnt", hz_if.stall_cnt, 0);
    rst = 1'b0;
    #1;
    check("rstpost_stall", hz_if.stall, 0);
    step();
    check("rstpost_cnt", hz_if.stall_cnt, 0);
    drain();
    exp_cnt = 0;

`ifndef HZ_FORWARD_EN
    // Endless reader/writer of $7: stalls 3 of every 4 cycles until saturation
    issue(1, 7, 0, 1, 0, 1, 7, 0, 0);
    check("sat_first_stall", hz_if.stall, 0);
    step();
    check("sat_stall", hz_if.stall, 1);
    check("sat_fwda", hz_if.fwda, FWD_RF);
    repeat (7) step();
    check("sat_rate", hz_if.stall_cnt, 6);
    begin
      int n;
      n = 0;
      while ((hz_if.stall_cnt != 16'hFFFF) && (n < 90000)) begin
        step();
        n++;
      end
    end
    check("sat_reach", hz_if.stall_cnt, 16'hFFFF);
    repeat (8) step();
    check("sat_hold", hz_if.stall_cnt, 16'hFFFF);
    idle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
